placar_display_scan: RTL and testbench

//  Downstream stage of the two-team scoreboard. Consumes both 7-bit binary team scores.

---
 rtl/placar_display_scan_pkg.sv | 47 ++++
 rtl/bcd_to_7seg.sv | 29 ++
 rtl/placar_display_scan.sv | 141 ++++++++++++++
 tb/tb_placar_display_scan.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/placar_display_scan_pkg.sv
// Shared types, segment patterns and the double-dabble step for the scoreboard display stage.
package placar_display_scan_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned ITER_W  = 3;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

  // One double-dabble iteration: correct nibbles >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern, with forced blanking.
module bcd_to_7seg
  import placar_display_scan_pkg::*;
(
  input  logic [3:0]       digit,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/placar_display_scan.sv
// Converts two binary team scores to BCD and scans them onto a 4-digit multiplexed display.
module placar_display_scan
  import placar_display_scan_pkg::*;
#(
  parameter int unsigned DIV_MAX = 50000,
  parameter int unsigned DIV_W   = 16
) (
  input  logic               clock,
  input  logic               clr,
  input  logic [SCORE_W-1:0] somaTime1,
  input  logic [SCORE_W-1:0] somaTime2,
  output logic [SEG_W-1:0]   seg,
  output logic [AN_W-1:0]    an,
  output logic               ovf
);

  logic [DIV_W-1:0]   div;
  logic               tick_c;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt_c;
  state_t             state;
  state_t             state_nxt;
  logic [SCORE_W-1:0] sh1;
  logic [SCORE_W-1:0] sh2;
  logic [BCD_W-1:0]   acc1;
  logic [BCD_W-1:0]   acc2;
  logic [ITER_W-1:0]  iter;
  bcd2_t              disp1;
  bcd2_t              disp2;
  bcd2_t              res1_c;
  bcd2_t              res2_c;
  logic               sat1_c;
  logic               sat2_c;
  logic [3:0]         mux_digit_c;
  logic               mux_blank_c;
  logic [SEG_W-1:0]   seg_c;

  // Scan tick divider
  assign tick_c = (div == DIV_W'(DIV_MAX - 1));

  always_ff @(posedge clock or negedge clr) begin
    if (!clr)        div <= '0;
    else if (tick_c) div <= '0;
    else             div <= div + DIV_W'(1);
  end

  // Digit mux selects the digit that becomes active on the coming tick
  assign idx_nxt_c = idx + IDX_W'(1);

  always_comb begin
    mux_digit_c = disp1.units;
    mux_blank_c = 1'b0;
    case (idx_nxt_c)
      2'd0: mux_digit_c = disp1.units;
      2'd1: begin mux_digit_c = disp1.tens; mux_blank_c = (disp1.tens == 4'd0); end
      2'd2: mux_digit_c = disp2.units;
      2'd3: begin mux_digit_c = disp2.tens; mux_blank_c = (disp2.tens == 4'd0); end
      default: ;
    endcase
  end

  bcd_to_7seg u_seg (
    .digit (mux_digit_c),
    .blank (mux_blank_c),
    .seg   (seg_c)
  );

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      idx <= '0;
      an  <= 4'hF;
      seg <= SEG_BLANK;
    end else if (tick_c) begin
      idx <= idx_nxt_c;
      an  <= ~(AN_W'(1) << idx_nxt_c);
      seg <= seg_c;
    end
  end

  // Conversion FSM state register
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick_c) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (iter == ITER_W'(6)) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scores with a nonzero hundreds digit cannot be shown and saturate to 99
  always_comb begin
    sat1_c = (acc1[11:8] != 4'd0);
    sat2_c = (acc2[11:8] != 4'd0);
    res1_c = sat1_c ? bcd2_t'({4'd9, 4'd9}) : bcd2_t'(acc1[7:0]);
    res2_c = sat2_c ? bcd2_t'({4'd9, 4'd9}) : bcd2_t'(acc2[7:0]);
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      sh1   <= '0;
      sh2   <= '0;
      acc1  <= '0;
      acc2  <= '0;
      iter  <= '0;
      disp1 <= '0;
      disp2 <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          sh1  <= somaTime1;
          sh2  <= somaTime2;
          acc1 <= '0;
          acc2 <= '0;
          iter <= '0;
        end
        S_SHIFT: begin
          acc1 <= dabble_step(acc1, sh1[SCORE_W-1]);
          acc2 <= dabble_step(acc2, sh2[SCORE_W-1]);
          sh1  <= {sh1[SCORE_W-2:0], 1'b0};
          sh2  <= {sh2[SCORE_W-2:0], 1'b0};
          iter <= iter + ITER_W'(1);
        end
        S_WRITE: begin
          disp1 <= res1_c;
          disp2 <= res2_c;
          ovf   <= sat1_c | sat2_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_placar_display_scan.sv
// Directed bench for the scoreboard display scanner with a short scan period.
module tb_placar_display_scan;

  logic       clock;
  logic       clr;
  logic [6:0] somaTime1;
  logic [6:0] somaTime2;
  logic [6:0] seg;
  logic [3:0] an;
  logic       ovf;

  int checks;
  int errors;

  placar_display_scan #(.DIV_MAX(4), .DIV_W(4)) dut (
    .clock     (clock),
    .clr       (clr),
    .somaTime1 (somaTime1),
    .somaTime2 (somaTime2),
    .seg       (seg),
    .an        (an),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bounded wait until the given digit is enabled; sampled 1ns after the rising edge
  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (an !== target && n < 40);
    if (an !== target) begin
      checks++;
      errors++;
      $display("FAIL wait_an: an=%b required %b", an, target);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    somaTime1 = 7'd0;
    somaTime2 = 7'd0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: seg=%b required %b", seg, 7'h7F); end
    checks++; if (an !== 4'hF)   begin errors++; $display("FAIL reset_an: an=%b required %b", an, 4'hF); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: ovf=%b required 0", ovf); end
    @(negedge clock);
    clr = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL pre_tick_an: an=%b required %b", an, 4'hF); end
    @(posedge clock);
    #1;
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL first_tick_an: an=%b required 1101", an); end
    checks++; if (seg !== 7'h7F)  begin errors++; $display("FAIL first_tick_seg: seg=%b required 1111111", seg); end
  endtask

  task automatic test_scan();
    somaTime1 = 7'd25;
    somaTime2 = 7'd7;
    repeat (30) @(posedge clock);
    wait_an(4'b1110);
    checks++; if (seg !== 7'b0010010) begin errors++; $display("FAIL scan_t1_units: seg=%b required 0010010", seg); end
    wait_an(4'b1101);
    checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL scan_t1_tens: seg=%b required 0100100", seg); end
    wait_an(4'b1011);
    checks++; if (seg !== 7'b1111000) begin errors++; $display("FAIL scan_t2_units: seg=%b required 1111000", seg); end
    wait_an(4'b0111);
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL scan_t2_tens_blank: seg=%b required 1111111", seg); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL scan_ovf: ovf=%b required 0", ovf); end
  endtask

  task automatic test_zero();
    somaTime1 = 7'd0;
    repeat (30) @(posedge clock);
    wait_an(4'b1110);
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL zero_units: seg=%b required 1000000", seg); end
    wait_an(4'b1101);
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL zero_tens_blank: seg=%b required 1111111", seg); end
  endtask

  task automatic test_overflow();
    somaTime1 = 7'd127;
    repeat (30) @(posedge clock);
    #1;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: ovf=%b required 1", ovf); end
    wait_an(4'b1110);
    checks++; if (seg !== 7'b0010000) begin errors++; $display("FAIL sat_units: seg=%b required 0010000", seg); end
    wait_an(4'b1101);
    checks++; if (seg !== 7'b0010000) begin errors++; $display("FAIL sat_tens: seg=%b required 0010000", seg); end
    somaTime1 = 7'd98;
    repeat (30) @(posedge clock);
    #1;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: ovf=%b required 0", ovf); end
    wait_an(4'b1110);
    checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL s98_units: seg=%b required 0000000", seg); end
    wait_an(4'b1101);
    checks++; if (seg !== 7'b0010000) begin errors++; $display("FAIL s98_tens: seg=%b required 0010000", seg); end
  endtask

  // Reset gives a known tick phase: tick at edge 4, LOAD captures at edge 5, WRITE at 13 and 25
  task automatic test_change_during_conversion();
    somaTime1 = 7'd25;
    somaTime2 = 7'd7;
    @(negedge clock);
    clr = 1'b0;
    @(negedge clock);
    clr = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    somaTime2 = 7'd88;
    repeat (19) @(posedge clock);
    #1;
    checks++; if (an !== 4'b1011)     begin errors++; $display("FAIL mid_old_an: an=%b required 1011", an); end
    checks++; if (seg !== 7'b1111000) begin errors++; $display("FAIL mid_old_units: seg=%b required 1111000", seg); end
    repeat (4) @(posedge clock);
    #1;
    checks++; if (an !== 4'b0111)     begin errors++; $display("FAIL mid_new_an: an=%b required 0111", an); end
    checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL mid_new_tens: seg=%b required 0000000", seg); end
    repeat (12) @(posedge clock);
    #1;
    checks++; if (an !== 4'b1011)     begin errors++; $display("FAIL mid_new_an2: an=%b required 1011", an); end
    checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL mid_new_units: seg=%b required 0000000", seg); end
  endtask

  task automatic test_free_run();
    logic [3:0] exp_an [4];
    logic [3:0] prev;
    int n;
    exp_an[0] = 4'b1101;
    exp_an[1] = 4'b1011;
    exp_an[2] = 4'b0111;
    exp_an[3] = 4'b1110;
    wait_an(4'b1110);
    prev = an;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clock);
        #1;
        n++;
      end while (an === prev && n < 10);
      checks++; if (n !== 4) begin errors++; $display("FAIL free_run_period[%0d]: clocks=%0d required 4", k, n); end
      checks++; if (an !== exp_an[k]) begin errors++; $display("FAIL free_run_an[%0d]: an=%b required %b", k, an, exp_an[k]); end
      prev = an;
    end
  endtask

  task automatic test_async_reset();
    somaTime1 = 7'd127;
    repeat (30) @(posedge clock);
    #1;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pre_clr_ovf: ovf=%b required 1", ovf); end
    @(posedge clock);
    #2;
    clr = 1'b0;
    #1;
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg: seg=%b required 1111111", seg); end
    checks++; if (an !== 4'hF)   begin errors++; $display("FAIL async_an: an=%b required 1111", an); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL async_ovf: ovf=%b required 0", ovf); end
    @(negedge clock);
    clr = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan();
    test_zero();
    test_overflow();
    test_change_during_conversion();
    test_free_run();
    test_async_reset();
    repeat (4) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
